// File: rtl/vx_rop_dcr_streamer.sv
// rtl/vx_rop_dcr_streamer.sv - ROP state snapshot to DCR write streamer with changed-register filter
package vx_rop_pkg;

    localparam int DCR_ADDR_BITS = 12;
    localparam int NUM_ROP_DCRS  = 18;

    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STATE_BEGIN     = 12'h080;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_CBUF_ADDR       = DCR_ROP_STATE_BEGIN + 12'd0;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_CBUF_PITCH      = DCR_ROP_STATE_BEGIN + 12'd1;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_CBUF_WRITEMASK  = DCR_ROP_STATE_BEGIN + 12'd2;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_ZBUF_ADDR       = DCR_ROP_STATE_BEGIN + 12'd3;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_ZBUF_PITCH      = DCR_ROP_STATE_BEGIN + 12'd4;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_DEPTH_FUNC      = DCR_ROP_STATE_BEGIN + 12'd5;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_DEPTH_WRITEMASK = DCR_ROP_STATE_BEGIN + 12'd6;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_FUNC    = DCR_ROP_STATE_BEGIN + 12'd7;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_ZPASS   = DCR_ROP_STATE_BEGIN + 12'd8;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_ZFAIL   = DCR_ROP_STATE_BEGIN + 12'd9;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_FAIL    = DCR_ROP_STATE_BEGIN + 12'd10;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_REF     = DCR_ROP_STATE_BEGIN + 12'd11;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_MASK    = DCR_ROP_STATE_BEGIN + 12'd12;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_WRITEMASK = DCR_ROP_STATE_BEGIN + 12'd13;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_BLEND_MODE      = DCR_ROP_STATE_BEGIN + 12'd14;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_BLEND_FUNC      = DCR_ROP_STATE_BEGIN + 12'd15;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_BLEND_CONST     = DCR_ROP_STATE_BEGIN + 12'd16;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_LOGIC_OP        = DCR_ROP_STATE_BEGIN + 12'd17;

    typedef struct packed {
        logic [31:0] cbuf_addr;
        logic [31:0] cbuf_pitch;
        logic [3:0]  cbuf_writemask;
        logic [31:0] zbuf_addr;
        logic [31:0] zbuf_pitch;
        logic        depth_enable;
        logic [2:0]  depth_func;
        logic        depth_writemask;
        logic        stencil_front_enable;
        logic        stencil_back_enable;
        logic [2:0]  stencil_front_func;
        logic [2:0]  stencil_back_func;
        logic [2:0]  stencil_front_zpass;
        logic [2:0]  stencil_back_zpass;
        logic [2:0]  stencil_front_zfail;
        logic [2:0]  stencil_back_zfail;
        logic [2:0]  stencil_front_fail;
        logic [2:0]  stencil_back_fail;
        logic [7:0]  stencil_front_ref;
        logic [7:0]  stencil_back_ref;
        logic [7:0]  stencil_front_mask;
        logic [7:0]  stencil_back_mask;
        logic [7:0]  stencil_front_writemask;
        logic [7:0]  stencil_back_writemask;
        logic        blend_enable;
        logic [2:0]  blend_mode_rgb;
        logic [2:0]  blend_mode_a;
        logic [3:0]  blend_src_rgb;
        logic [3:0]  blend_src_a;
        logic [3:0]  blend_dst_rgb;
        logic [3:0]  blend_dst_a;
        logic [7:0]  blend_const_r;
        logic [7:0]  blend_const_g;
        logic [7:0]  blend_const_b;
        logic [7:0]  blend_const_a;
        logic [3:0]  logic_op;
    } rop_dcrs_t;

endpackage

module vx_rop_dcr_streamer
    import vx_rop_pkg::*;
#(
    parameter bit FORCE_FULL_DEFAULT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  rop_dcrs_t                req_dcrs,
    input  logic                     req_force,
    output logic                     dcr_wr_valid,
    input  logic                     dcr_wr_ready,
    output logic [DCR_ADDR_BITS-1:0] dcr_wr_addr,
    output logic [31:0]              dcr_wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [NUM_ROP_DCRS-1:0][31:0] pack_dcrs(input rop_dcrs_t d);
        logic [NUM_ROP_DCRS-1:0][31:0] p;
        p[0]  = d.cbuf_addr;
        p[1]  = d.cbuf_pitch;
        p[2]  = {28'b0, d.cbuf_writemask};
        p[3]  = d.zbuf_addr;
        p[4]  = d.zbuf_pitch;
        p[5]  = {29'b0, d.depth_func};
        p[6]  = {31'b0, d.depth_writemask};
        p[7]  = {13'b0, d.stencil_back_func,  13'b0, d.stencil_front_func};
        p[8]  = {13'b0, d.stencil_back_zpass, 13'b0, d.stencil_front_zpass};
        p[9]  = {13'b0, d.stencil_back_zfail, 13'b0, d.stencil_front_zfail};
        p[10] = {13'b0, d.stencil_back_fail,  13'b0, d.stencil_front_fail};
        p[11] = {8'b0, d.stencil_back_ref,  8'b0, d.stencil_front_ref};
        p[12] = {8'b0, d.stencil_back_mask, 8'b0, d.stencil_front_mask};
        p[13] = {8'b0, d.stencil_back_writemask, 8'b0, d.stencil_front_writemask};
        p[14] = {13'b0, d.blend_mode_a, 13'b0, d.blend_mode_rgb};
        p[15] = {d.blend_dst_a, 4'b0, d.blend_dst_rgb, 4'b0, d.blend_src_a, 4'b0, d.blend_src_rgb};
        p[15] = {4'b0, d.blend_dst_a, 4'b0, d.blend_dst_rgb, 4'b0, d.blend_src_a, 4'b0, d.blend_src_rgb};
        p[16] = {d.blend_const_a, d.blend_const_r, d.blend_const_g, d.blend_const_b};
        p[17] = {28'b0, d.logic_op};
        return p;
    endfunction

    // Enables are implied by the function fields on the receiving side.
    logic unused_enables;
    assign unused_enables = ^{req_dcrs.depth_enable, req_dcrs.stencil_front_enable,
                              req_dcrs.stencil_back_enable, req_dcrs.blend_enable};

    logic [1:0]                     state_q, state_d;
    logic [NUM_ROP_DCRS-1:0]        dirty_q, dirty_d;
    logic [NUM_ROP_DCRS-1:0]        shadow_valid_q, shadow_valid_d;
    logic [NUM_ROP_DCRS-1:0][31:0]  data_q;
    logic [NUM_ROP_DCRS-1:0][31:0]  shadow_q;
    logic [NUM_ROP_DCRS-1:0][31:0]  packed_w;
    logic [NUM_ROP_DCRS-1:0]        req_mask;
    logic [NUM_ROP_DCRS-1:0]        sel_onehot;
    logic [4:0]                     sel_idx;
    logic [31:0]                    sel_data;
    logic                           accept;
    logic                           wr_fire;

    assign packed_w = pack_dcrs(req_dcrs);
    assign accept   = req_valid && (state_q == ST_IDLE);
    assign wr_fire  = (state_q == ST_SEND) && dcr_wr_ready;

    always_comb begin
        req_mask = '0;
        for (int i = 0; i < NUM_ROP_DCRS; i++) begin
            req_mask[i] = req_force | FORCE_FULL_DEFAULT | !shadow_valid_q[i]
                        | (packed_w[i] != shadow_q[i]);
        end
    end

    // Lowest pending index wins; walking downward lets the last hit be the lowest.
    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_data   = '0;
        for (int i = NUM_ROP_DCRS - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_idx       = 5'(i);
            end
        end
        for (int i = 0; i < NUM_ROP_DCRS; i++) begin
            sel_data = sel_data | (data_q[i] & {32{sel_onehot[i]}});
        end
    end

    always_comb begin
        state_d        = state_q;
        dirty_d        = dirty_q;
        shadow_valid_d = shadow_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    dirty_d = req_mask;
                    state_d = (|req_mask) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (dcr_wr_ready) begin
                    dirty_d        = dirty_q & ~sel_onehot;
                    shadow_valid_d = shadow_valid_q | sel_onehot;
                    if (dirty_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            dirty_q        <= '0;
            shadow_valid_q <= '0;
        end else begin
            state_q        <= state_d;
            dirty_q        <= dirty_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    // Payload registers are qualified by state/shadow_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= packed_w;
        end
        if (wr_fire) begin
            for (int i = 0; i < NUM_ROP_DCRS; i++) begin
                if (sel_onehot[i]) begin
                    shadow_q[i] <= data_q[i];
                end
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign dcr_wr_valid = (state_q == ST_SEND);
    assign dcr_wr_addr  = DCR_ROP_STATE_BEGIN + DCR_ADDR_BITS'(sel_idx);
    assign dcr_wr_data  = sel_data;

endmodule

// File: tb/tb_vx_rop_dcr_streamer.sv
// tb/tb_vx_rop_dcr_streamer.sv - self-checking bench for vx_rop_dcr_streamer
module tb_vx_rop_dcr_streamer;
    import vx_rop_pkg::*;

    localparam int W = $bits(rop_dcrs_t);

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    rop_dcrs_t                req_dcrs = '0;
    logic                     req_force = 1'b0;
    logic                     dcr_wr_valid;
    logic                     dcr_wr_ready = 1'b1;
    logic [DCR_ADDR_BITS-1:0] dcr_wr_addr;
    logic [31:0]              dcr_wr_data;
    logic                     busy;
    logic                     done;

    vx_rop_dcr_streamer #(.FORCE_FULL_DEFAULT(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dcrs     (req_dcrs),
        .req_force    (req_force),
        .dcr_wr_valid (dcr_wr_valid),
        .dcr_wr_ready (dcr_wr_ready),
        .dcr_wr_addr  (dcr_wr_addr),
        .dcr_wr_data  (dcr_wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_shadow [NUM_ROP_DCRS];
    bit          m_valid  [NUM_ROP_DCRS];
    logic [31:0] cap_data [NUM_ROP_DCRS];
    int          last_writes;
    int          last_cycles;
    rop_dcrs_t   cur;

    function automatic logic [31:0] model_word(input rop_dcrs_t s, input int i);
        case (i)
            0:  return s.cbuf_addr;
            1:  return s.cbuf_pitch;
            2:  return 32'(s.cbuf_writemask);
            3:  return s.zbuf_addr;
            4:  return s.zbuf_pitch;
            5:  return 32'(s.depth_func);
            6:  return 32'(s.depth_writemask);
            7:  return 32'(s.stencil_front_func)  + (32'(s.stencil_back_func)  << 16);
            8:  return 32'(s.stencil_front_zpass) + (32'(s.stencil_back_zpass) << 16);
            9:  return 32'(s.stencil_front_zfail) + (32'(s.stencil_back_zfail) << 16);
            10: return 32'(s.stencil_front_fail)  + (32'(s.stencil_back_fail)  << 16);
            11: return 32'(s.stencil_front_ref)   + (32'(s.stencil_back_ref)   << 16);
            12: return 32'(s.stencil_front_mask)  + (32'(s.stencil_back_mask)  << 16);
            13: return 32'(s.stencil_front_writemask) + (32'(s.stencil_back_writemask) << 16);
            14: return 32'(s.blend_mode_rgb) + (32'(s.blend_mode_a) << 16);
            15: return 32'(s.blend_src_rgb) + (32'(s.blend_src_a) << 8)
                     + (32'(s.blend_dst_rgb) << 16) + (32'(s.blend_dst_a) << 24);
            16: return (32'(s.blend_const_a) << 24) + (32'(s.blend_const_r) << 16)
                     + (32'(s.blend_const_g) << 8) + 32'(s.blend_const_b);
            default: return 32'(s.logic_op);
        endcase
    endfunction

    function automatic logic [DCR_ADDR_BITS-1:0] model_addr(input int i);
        case (i)
            0:  return DCR_ROP_CBUF_ADDR;
            1:  return DCR_ROP_CBUF_PITCH;
            2:  return DCR_ROP_CBUF_WRITEMASK;
            3:  return DCR_ROP_ZBUF_ADDR;
            4:  return DCR_ROP_ZBUF_PITCH;
            5:  return DCR_ROP_DEPTH_FUNC;
            6:  return DCR_ROP_DEPTH_WRITEMASK;
            7:  return DCR_ROP_STENCIL_FUNC;
            8:  return DCR_ROP_STENCIL_ZPASS;
            9:  return DCR_ROP_STENCIL_ZFAIL;
            10: return DCR_ROP_STENCIL_FAIL;
            11: return DCR_ROP_STENCIL_REF;
            12: return DCR_ROP_STENCIL_MASK;
            13: return DCR_ROP_STENCIL_WRITEMASK;
            14: return DCR_ROP_BLEND_MODE;
            15: return DCR_ROP_BLEND_FUNC;
            16: return DCR_ROP_BLEND_CONST;
            default: return DCR_ROP_LOGIC_OP;
        endcase
    endfunction

    function automatic rop_dcrs_t rand_dcrs();
        logic [W-1:0] v;
        for (int k = 0; k < W; k++) v[k] = 1'($urandom_range(0, 1));
        return rop_dcrs_t'(v);
    endfunction

    function automatic rop_dcrs_t mutate(input rop_dcrs_t s, input int nflips);
        logic [W-1:0] v;
        v = s;
        for (int k = 0; k < nflips; k++) v[$urandom_range(0, W - 1)] ^= 1'b1;
        return rop_dcrs_t'(v);
    endfunction

    // Drives one request; abort_at >= 0 pulls reset while write number abort_at is presented.
    task automatic run_request(input rop_dcrs_t s, input bit f, input int stall_idx,
                               input int stall_len, input bit rand_ready, input int abort_at);
        int  exp_q[$];
        int  cyc, vcyc, writes, stall_left, idx;
        bit  seen_done;
        for (int i = 0; i < NUM_ROP_DCRS; i++) begin
            cap_data[i] = 32'hDEAD_BEEF;
            if (f || !m_valid[i] || (model_word(s, i) != m_shadow[i])) exp_q.push_back(i);
        end
        @(negedge clk);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL req_ready_before: got %b expected 1", req_ready);
        else n_pass++;
        req_dcrs = s; req_force = f; req_valid = 1'b1; dcr_wr_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_force = 1'($urandom); req_dcrs = rand_dcrs();
        cyc = 0; vcyc = 0; writes = 0; stall_left = stall_len; seen_done = 0;
        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && dcr_wr_valid && writes == abort_at) begin
                reset = 1'b0; dcr_wr_ready = 1'b0;
                @(posedge clk); @(negedge clk);
                n_total++;
                if ({dcr_wr_valid, busy, done, req_ready} !== 4'b0001)
                    $display("FAIL reset_mid_send_idle: got vld/busy/done/rdy=%b expected 0001",
                             {dcr_wr_valid, busy, done, req_ready});
                else n_pass++;
                reset = 1'b1; dcr_wr_ready = 1'b1;
                for (int i = 0; i < NUM_ROP_DCRS; i++) m_valid[i] = 0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_total++;
                    if (done !== 1'b0 || dcr_wr_valid !== 1'b0)
                        $display("FAIL no_done_after_abort: got done=%b vld=%b expected 0 0", done, dcr_wr_valid);
                    else n_pass++;
                end
                last_writes = writes;
                return;
            end
            if (dcr_wr_valid) begin
                vcyc++;
                n_total++;
                if (busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0)
                    $display("FAIL send_flags: got busy=%b done=%b rdy=%b expected 1 0 0", busy, done, req_ready);
                else n_pass++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_write: got addr %0h expected no write", dcr_wr_addr);
                    dcr_wr_ready = 1'b1;
                end else begin
                    idx = exp_q[0];
                    n_total++;
                    if (dcr_wr_addr !== model_addr(idx) || dcr_wr_data !== model_word(s, idx))
                        $display("FAIL write_%0d: got addr %0h data %08h expected addr %0h data %08h",
                                 idx, dcr_wr_addr, dcr_wr_data, model_addr(idx), model_word(s, idx));
                    else n_pass++;
                    if (idx == stall_idx && stall_left > 0) begin
                        dcr_wr_ready = 1'b0; stall_left--;
                    end else if (rand_ready) begin
                        dcr_wr_ready = ($urandom_range(0, 3) != 0);
                    end else begin
                        dcr_wr_ready = 1'b1;
                    end
                    if (dcr_wr_ready) begin
                        void'(exp_q.pop_front());
                        m_shadow[idx] = model_word(s, idx);
                        m_valid[idx]  = 1;
                        cap_data[idx] = dcr_wr_data;
                        writes++;
                    end
                end
            end else if (done === 1'b1) begin
                seen_done = 1;
                n_total++;
                if (cyc != vcyc + 1 || exp_q.size() != 0 || busy !== 1'b1)
                    $display("FAIL done_timing: got cycle %0d pending %0d busy %b expected cycle %0d pending 0 busy 1",
                             cyc, exp_q.size(), busy, vcyc + 1);
                else n_pass++;
            end else begin
                n_total++;
                $display("FAIL bubble: got idle cycle %0d with %0d writes pending expected valid or done",
                         cyc, exp_q.size());
            end
        end
        if (!seen_done) begin
            n_total++;
            $display("FAIL timeout: got no done after %0d cycles expected done", cyc);
        end
        dcr_wr_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({req_ready, busy, done, dcr_wr_valid} !== 4'b1000)
            $display("FAIL back_to_idle: got rdy/busy/done/vld=%b expected 1000",
                     {req_ready, busy, done, dcr_wr_valid});
        else n_pass++;
        last_writes = writes;
        last_cycles = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({dcr_wr_valid, busy, done, req_ready} !== 4'b0001)
            $display("FAIL reset_state: got vld/busy/done/rdy=%b expected 0001",
                     {dcr_wr_valid, busy, done, req_ready});
        else n_pass++;
        reset = 1'b1;
        for (int i = 0; i < NUM_ROP_DCRS; i++) m_valid[i] = 0;
    endtask

    task automatic test_full_after_reset();
        cur = rand_dcrs();
        cur.stencil_back_ref = 8'h11;
        run_request(cur, 1'b0, -1, 0, 1'b0, -1);
        n_total++;
        if (last_writes != 18 || last_cycles != 19)
            $display("FAIL full_after_reset: got %0d writes done cycle %0d expected 18 writes cycle 19",
                     last_writes, last_cycles);
        else n_pass++;
    endtask

    task automatic test_repeat();
        run_request(cur, 1'b0, -1, 0, 1'b0, -1);
        n_total++;
        if (last_writes != 0 || last_cycles != 1)
            $display("FAIL repeat_snapshot: got %0d writes done cycle %0d expected 0 writes cycle 1",
                     last_writes, last_cycles);
        else n_pass++;
    endtask

    task automatic test_stencil_back_ref();
        cur.stencil_back_ref = 8'h5A;
        run_request(cur, 1'b0, -1, 0, 1'b0, -1);
        n_total++;
        if (last_writes != 1 || cap_data[11][31:16] !== 16'h005A
            || cap_data[11][15:0] !== {8'h00, cur.stencil_front_ref})
            $display("FAIL stencil_back_ref: got %0d writes data %08h expected 1 write data 005a00%02h",
                     last_writes, cap_data[11], cur.stencil_front_ref);
        else n_pass++;
    endtask

    task automatic test_stall();
        run_request(cur, 1'b1, 1, 3, 1'b0, -1);
        n_total++;
        if (last_writes != 18 || last_cycles != 22)
            $display("FAIL stall_pitch: got %0d writes done cycle %0d expected 18 writes cycle 22",
                     last_writes, last_cycles);
        else n_pass++;
    endtask

    task automatic test_force_blend_const();
        cur.blend_const_a = 8'h11; cur.blend_const_r = 8'h22;
        cur.blend_const_g = 8'h33; cur.blend_const_b = 8'h44;
        run_request(cur, 1'b0, -1, 0, 1'b0, -1);
        run_request(cur, 1'b1, -1, 0, 1'b0, -1);
        n_total++;
        if (last_writes != 18 || cap_data[16] !== 32'h11223344)
            $display("FAIL force_blend_const: got %0d writes data %08h expected 18 writes data 11223344",
                     last_writes, cap_data[16]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        run_request(cur, 1'b1, -1, 0, 1'b0, 4);
        n_total++;
        if (last_writes != 4)
            $display("FAIL abort_writes: got %0d writes expected 4", last_writes);
        else n_pass++;
        run_request(cur, 1'b0, -1, 0, 1'b0, -1);
        n_total++;
        if (last_writes != 18 || last_cycles != 19)
            $display("FAIL after_abort: got %0d writes done cycle %0d expected 18 writes cycle 19",
                     last_writes, last_cycles);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            cur = mutate(cur, $urandom_range(0, 6));
            run_request(cur, ($urandom_range(0, 7) == 0), -1, 0, 1'b1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_full_after_reset();
        test_repeat();
        test_stencil_back_ref();
        test_stall();
        test_force_blend_const();
        test_reset_mid_send();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
